frame_strobe_sequencer: RTL

//  Column-level configuration write controller for a fabric column of tiles.

---
 rtl/frame_strobe_sequencer.sv | 98 +++++++++
 1 files changed

// File: rtl/frame_strobe_sequencer.sv
// Column configuration write controller: gathers one word per tile row, then
// drives FrameData and fires a single registered FrameStrobe line.
module frame_strobe_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 4,
  parameter int StrobeCycles    = 2,
  localparam int FW             = $clog2(MaxFramesPerCol)
) (
  input  logic                                 UserCLK,
  input  logic                                 rst,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [FW-1:0]                        cmd_frame,
  input  logic                                 data_valid,
  output logic                                 data_ready,
  input  logic [FrameBitsPerRow-1:0]           data_in,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int SW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  localparam logic [RW-1:0] LastRow    = RW'(NumRows - 1);
  localparam logic [SW-1:0] LastStrobe = SW'(StrobeCycles - 1);
  localparam logic [FW:0]   FrameLimit = (FW+1)'(MaxFramesPerCol);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD} state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [SW-1:0] scnt;
  logic [FW-1:0] frame;

  assign cmd_ready  = (state == IDLE);
  assign data_ready = (state == LOAD);
  assign busy       = (state != IDLE);

  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      FrameData   <= '0;
      FrameStrobe <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      row         <= '0;
      scnt        <= '0;
      frame       <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            frame <= cmd_frame;
            if ({1'b0, cmd_frame} >= FrameLimit) begin
              err <= 1'b1;
            end else begin
              row   <= '0;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (data_valid) begin
            FrameData[row*FrameBitsPerRow +: FrameBitsPerRow] <= data_in;
            if (row == LastRow) state <= SETUP;
            else                row   <= row + 1'b1;
          end
        end
        SETUP: begin
          // Strobe is registered here so it rises on the first STROBE cycle.
          FrameStrobe        <= '0;
          FrameStrobe[frame] <= 1'b1;
          scnt               <= '0;
          state              <= STROBE;
        end
        STROBE: begin
          if (scnt == LastStrobe) begin
            FrameStrobe <= '0;
            state       <= HOLD;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        HOLD: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
